ascii_uart_tx: RTL and testbench

- Downstream consumer of the transform character stream.
- Accepts ASCII bytes (function / Laplace-transform text) over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte as 8N1 UART on a single output pin, so a host terminal can read the rendered LaTeX.
- Sits between the transformer's character outputs and a spare top-level output pin.

---
 rtl/ascii_uart_pkg.sv | 17 +
 rtl/char_fifo.sv | 63 ++++++
 rtl/ascii_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_ascii_uart_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_uart_pkg.sv
// rtl/ascii_uart_pkg.sv - shared FSM state type and ASCII/UART constants for ascii_uart_tx
package ascii_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - FIFO_DEPTH x WIDTH character buffer with MSB-compare full/empty
module char_fifo
  import ascii_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = UART_DATA_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes a full wrap from an empty buffer.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// rtl/ascii_uart_tx.sv - buffered 8N1 UART transmitter for the transform character stream
// ASCII_UART_TX_CRLF_EN: send a dequeued NUL as CR then LF.
module ascii_uart_tx
  import ascii_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       tx,
  output logic       busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          avail_q;
  logic          baud_done;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

`ifdef ASCII_UART_TX_CRLF_EN
  logic          lf_pend_q, lf_pend_d;
`endif

  assign char_ready = !fifo_full;
  assign fifo_push  = char_valid && !fifo_full;
  assign baud_done  = (baud_q == BAUD_LAST);
  assign tx         = tx_q;
  assign busy       = busy_q;

  char_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (char_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
`ifdef ASCII_UART_TX_CRLF_EN
    lf_pend_d = lf_pend_q;
`endif

    case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        // avail_q lags the FIFO by one cycle, fixing accept-to-start latency at two edges.
`ifdef ASCII_UART_TX_CRLF_EN
        if (lf_pend_q) begin
          shift_d   = ASCII_LF;
          lf_pend_d = 1'b0;
          state_d   = START;
        end else if (avail_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
          if (fifo_dout == ASCII_NUL) begin
            shift_d   = ASCII_CR;
            lf_pend_d = 1'b1;
          end else begin
            shift_d = fifo_dout;
          end
        end
`else
        if (avail_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
        end
`endif
      end

      START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    // Line level follows the next state so tx changes on the same edge as the FSM.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    // A pop always moves the FSM out of IDLE, so push alone decides FIFO occupancy here.
    busy_d = (state_d != IDLE) || !fifo_empty || fifo_push;
`ifdef ASCII_UART_TX_CRLF_EN
    busy_d = busy_d || lf_pend_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      avail_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      avail_q   <= !fifo_empty;
    end
  end

`ifdef ASCII_UART_TX_CRLF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lf_pend_q <= 1'b0;
    end else begin
      lf_pend_q <= lf_pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_ascii_uart_tx.sv
// tb/tb_ascii_uart_tx.sv - directed self-checking bench for ascii_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_ascii_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  int         start_q[$];
  int         cyc = 0;
  int         mon_k = -1;
  logic [7:0] mon_byte;
  int         rx_cnt = 0;
  int         acc_frames = 0;
  int         acc_next = 0;
  int         busy_err = 0;
  int         frm_err = 0;

  ascii_uart_tx #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int frames_for(input logic [7:0] b);
`ifdef ASCII_UART_TX_CRLF_EN
    return (b == 8'h00) ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  // UART decoder and busy-invariant tracker, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    acc_frames += acc_next;
    acc_next = 0;
    if (rst) begin
      mon_k = -1;
      acc_frames = rx_cnt;
    end else begin
      if (char_valid === 1'b1 && char_ready === 1'b1) acc_next = frames_for(char_in);
      if (busy === 1'b0 && (mon_k >= 0 || acc_frames != rx_cnt || tx !== 1'b1)) busy_err++;
      if (mon_k < 0 && tx === 1'b0) begin
        mon_k = 0;
        start_q.push_back(cyc);
      end
      if (mon_k >= 0) begin
        if (mon_k >= 6 && mon_k <= 34 && ((mon_k - 6) % 4) == 0) mon_byte[(mon_k - 6) / 4] = tx;
        if (mon_k == 38) begin
          if (tx !== 1'b1) frm_err++;
          rx_q.push_back(mon_byte);
          rx_cnt++;
        end
        if (mon_k == 39) mon_k = -1;
        else mon_k++;
      end
    end
  end

  task automatic send(input logic [7:0] b, output int waited);
    waited = 0;
    char_in = b;
    char_valid = 1'b1;
    while (char_ready !== 1'b1 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    check("send_accept", char_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_k >= 0) && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drain_timeout"}, (n >= 6000), 0);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] exp[$]);
    check({tag, "_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp[i]);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp[$];
    logic [9:0] f41;
    int         w;
    int         stalls;
    int         bad;
    int         acc_t[$];
    logic [7:0] b;

    rst = 1'b1;
    char_valid = 1'b0;
    char_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", char_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte 0x41: start bit two edges after acceptance, then 1,0,0,0,0,0,1,0, stop.
    rx_q.delete();
    start_q.delete();
    send(8'h41, w);
    char_valid = 1'b0;
    check("lat_e0_tx", tx, 1);
    check("lat_e0_busy", busy, 1);
    @(posedge clk); #1;
    check("lat_e1_tx", tx, 1);
    f41 = 10'b1010000010;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check($sformatf("frame41_k%0d", k), tx, f41[k / 4]);
    end
    check("busy_last_stop", busy, 1);
    @(posedge clk); #1;
    check("busy_end", busy, 0);
    check("idle_tx", tx, 1);
    exp = {8'h41};
    check_seq("single", exp);

    // Reset during data bit 3 aborts the frame.
    rx_q.delete();
    send(8'h41, w);
    char_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("mid_bit3", tx, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", char_ready, 1);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_rst_quiet", bad, 0);
    check("post_rst_rx", rx_q.size(), 0);

    // Back-to-back "\frac": ready drops once four are buffered and one is in flight.
    rx_q.delete();
    start_q.delete();
    exp = {8'h5C, 8'h66, 8'h72, 8'h61, 8'h63};
    stalls = 0;
    foreach (exp[i]) begin
      send(exp[i], w);
      stalls += w;
    end
    check("b2b_ready_full", char_ready, 0);
    check("b2b_stalls", stalls, 0);
    char_valid = 1'b0;
    drain("b2b");
    check_seq("b2b", exp);
    check("b2b_starts", start_q.size(), 5);
    for (int i = 0; i + 1 < start_q.size(); i++) begin
      check($sformatf("b2b_gap%0d", i), start_q[i + 1] - start_q[i], 41);
    end

    // Full boundary: 16 bytes with char_valid held, one accept per pop once full.
    rx_q.delete();
    exp.delete();
    acc_t.delete();
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'h30 + 8'(i);
      exp.push_back(b);
      send(b, w);
      stalls += w;
      acc_t.push_back(cyc);
    end
    char_valid = 1'b0;
    check("full_stalled", (stalls > 0), 1);
    bad = 0;
    for (int i = 6; i < acc_t.size(); i++) begin
      if (acc_t[i] - acc_t[i - 1] != 41) bad++;
    end
    check("full_accept_period", bad, 0);
    drain("full");
    check_seq("full", exp);

    // End-of-line marker.
    rx_q.delete();
    start_q.delete();
    send(8'h73, w);
    send(8'h00, w);
    char_valid = 1'b0;
    drain("crlf");
`ifdef ASCII_UART_TX_CRLF_EN
    exp = {8'h73, 8'h0D, 8'h0A};
`else
    exp = {8'h73, 8'h00};
`endif
    check_seq("crlf", exp);

    // Random stress with idle gaps on char_valid.
    rx_q.delete();
    exp.delete();
    for (int i = 0; i < 200; i++) begin
      b = 8'($urandom_range(1, 255));
      exp.push_back(b);
      send(b, w);
      w = $urandom_range(0, 3);
      if (w > 0) begin
        char_valid = 1'b0;
        repeat (w) @(posedge clk);
        #1;
      end
    end
    char_valid = 1'b0;
    drain("rand");
    check_seq("rand", exp);

    check("busy_invariant", busy_err, 0);
    check("framing", frm_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
